// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock.
// A three-state FSM (IDLE/CALC/DONE) steers the accumulator, the shift
// register and the add/subtract unit. Operands are captured on the
// accepting edge, and the product register holds its value until the
// next result is written.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Wide enough to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  // Accumulator and multiplicand carry one guard bit so that -(-2^(W-1))
  // is representable.
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     a_add;
  logic [WIDTH:0]     a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               last_step;

  // Booth step: add/sub selected by {Q[0],Q_1}, then arithmetic shift right.
  always_comb begin
    a_add = a_q;
    unique case ({q_q[0], q1_q})
      2'b01:   a_add = a_q + m_q;
      2'b10:   a_add = a_q - m_q;
      default: a_add = a_q;
    endcase
    a_sh      = {a_add[WIDTH], a_add[WIDTH:1]};
    q_sh      = {a_add[0], q_q[WIDTH-1:1]};
    last_step = (cnt_q == CNT_ONE);
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = '0;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          q_d     = multiplier;
          q1_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q - CNT_ONE;
        if (last_step) begin
          // The guard bit is pure sign extension once all steps are done.
          prod_d  = {a_sh[WIDTH-1:0], q_sh};
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): directed cases, ignored
// start, mid-operation reset, back-to-back operation and a random sweep
// compared against a plain signed-multiply reference.
module tb_booth_mult_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready, busy, done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Reference: full-precision signed product truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    longint sm, sq;
    sm = longint'($signed(m));
    sq = longint'($signed(q));
    return (2*W)'(sm * sq);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, then scramble the operand inputs during the
  // calculation. Returns the product and the number of edges after the
  // accepting edge until done is seen (99 on timeout).
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        output logic [2*W-1:0] prod, output int lat);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    tick();
    start = 1'b0;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) lat = 99;
    prod = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags got=%b want=100", {ready, busy, done});
    end
    total++;
    if (product !== 16'h0000) begin
      bad++;
      $display("FAIL reset_product got=%h want=0000", product);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0]   ms [6] = '{8'h03, 8'hFD, 8'h07, 8'h80, 8'h7F, 8'h00};
    logic [W-1:0]   qs [6] = '{8'h05, 8'h05, 8'hFF, 8'h80, 8'h80, 8'h5A};
    logic [2*W-1:0] ex [6] = '{16'h000F, 16'hFFF1, 16'hFFF9, 16'h4000, 16'hC080, 16'h0000};
    logic [2*W-1:0] p;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ms[i], qs[i], p, lat);
      total++;
      if (p !== ex[i]) begin
        bad++;
        $display("FAIL directed_product[%0d] got=%h want=%h", i, p, ex[i]);
      end
      total++;
      if (lat != W) begin
        bad++;
        $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, W);
      end
      tick();
      total++;
      if ({ready, busy, done} !== 3'b100 || product !== ex[i]) begin
        bad++;
        $display("FAIL directed_after[%0d] flags=%b prod=%h want flags=100 prod=%h",
                 i, {ready, busy, done}, product, ex[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra = 0;
    start = 1'b1;
    multiplicand = 8'h03;
    multiplier = 8'h05;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL ignore_busy got=%b want=01", {ready, busy});
    end
    start = 1'b1;
    multiplicand = 8'h11;
    multiplier = 8'h22;
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (!done || lat != W || product !== 16'h000F) begin
      bad++;
      $display("FAIL ignore_result done=%b lat=%0d prod=%h want done=1 lat=%0d prod=000F",
               done, lat, product, W);
    end
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) extra++;
    end
    total++;
    if (extra != 0 || product !== 16'h000F) begin
      bad++;
      $display("FAIL ignore_no_second extra_done=%0d prod=%h want 0 / 000F", extra, product);
    end
  endtask

  task automatic test_mid_reset();
    logic [2*W-1:0] p;
    int lat;
    int seen = 0;
    start = 1'b1;
    multiplicand = 8'h05;
    multiplier = 8'h07;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({ready, busy, done} !== 3'b100 || product !== 16'h0000) begin
      bad++;
      $display("FAIL midreset_state flags=%b prod=%h want 100 / 0000", {ready, busy, done}, product);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || !ready) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_quiet got=%0d want=0", seen);
    end
    run_op(8'hFF, 8'hFF, p, lat);
    total++;
    if (p !== 16'h0001 || lat != W) begin
      bad++;
      $display("FAIL midreset_fresh prod=%h lat=%0d want 0001 / %0d", p, lat, W);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx [$];
    int nbad = 0;
    start = 1'b1;
    multiplicand = 8'h02;
    multiplier = 8'h03;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) begin
        idx.push_back(k);
        if (product !== 16'h0006) nbad++;
      end
    end
    start = 1'b0;
    total++;
    if (idx.size() != 3 || nbad != 0) begin
      bad++;
      $display("FAIL b2b_count dones=%0d wrong_products=%0d want 3 / 0", idx.size(), nbad);
    end
    for (int i = 1; i < idx.size(); i++) begin
      total++;
      if (idx[i] - idx[i-1] != W + 2) begin
        bad++;
        $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, idx[i] - idx[i-1], W + 2);
      end
    end
    tick(); tick();
  endtask

  task automatic test_random();
    logic [W-1:0]   m, q;
    logic [2*W-1:0] p, exp;
    int lat;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      m = W'($urandom);
      q = W'($urandom);
      if (i == 0) begin m = 8'h80; q = 8'h80; end
      if (i == 1) begin m = 8'h80; q = 8'h7F; end
      exp = ref_mul(m, q);
      run_op(m, q, p, lat);
      total++;
      if (p !== exp || lat != W) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d] m=%h q=%h got=%h lat=%0d want=%h lat=%0d", i, m, q, p, lat, exp, W);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
